// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Definitions shared by the ALU result stage:
//   - bit positions of the N, Z, C and V flags inside the 4-bit nzcv word
//   - bit positions of V and C inside the adder's 2-bit flag_in bus
//   - occupancy state encoding of the 2-entry result buffer
//   - pack_nzcv(): assembles an nzcv word from its four flag bits
// ---------------------------------------------------------------------------
package alu_pkg;

  // Positions inside the nzcv word, ordered {N,Z,C,V}.
  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  // Positions inside the adder flag bus.
  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;

  // Number of entries currently held by the result buffer.
  typedef enum logic [1:0] {
    VACIO = 2'd0,
    UNO   = 2'd1,
    LLENO = 2'd2
  } ocupacion_t;

  function automatic logic [3:0] pack_nzcv(input logic n, input logic z,
                                           input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[NZCV_N] = n;
    f[NZCV_Z] = z;
    f[NZCV_C] = c;
    f[NZCV_V] = v;
    return f;
  endfunction

endpackage : alu_pkg

// File: rtl/etapa_resultado_alu_if.sv
// ---------------------------------------------------------------------------
// etapa_resultado_alu_if
// Valid/ready bus of the ALU result stage. It has an upstream side, carrying
// the adder sum and flags, and a downstream side, carrying the buffered
// result and its nzcv flags.
//   in_valid  : the adder sum and flags are valid
//   in_ready  : the stage accepts a transfer this cycle
//   c_in      : N-bit adder sum
//   flag_in   : adder flags, bit0 = V, bit1 = C
//   out_valid : result and nzcv hold a valid entry
//   out_ready : the consumer takes the head entry
//   result    : buffered sum at the head of the buffer
//   nzcv      : buffered flags at the head, ordered {N,Z,C,V}
// Modports:
//   master : environment side (adder producer and result consumer)
//   slave  : stage side
// ---------------------------------------------------------------------------
interface etapa_resultado_alu_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] c_in;
  logic [1:0]   flag_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic [3:0]   nzcv;

  modport master (
    output in_valid, c_in, flag_in, out_ready,
    input  in_ready, out_valid, result, nzcv
  );

  modport slave (
    input  in_valid, c_in, flag_in, out_ready,
    output in_ready, out_valid, result, nzcv
  );
endinterface : etapa_resultado_alu_if

// File: rtl/etapa_resultado_alu_buffer_resultado.sv
// ---------------------------------------------------------------------------
// buffer_resultado
// Storage for the two-entry in-order {result, nzcv} buffer. The buffer holds
// two registers. The head register drives the stage outputs. The tail
// register holds the second entry while the buffer is full. The caller
// decides the occupancy and tells the buffer which register to load.
//   clk, rst_n     : clock and asynchronous active-low reset
//   load_head      : write the head this cycle
//   head_from_tail : head source select, 1 = tail (advance), 0 = wr_data
//   load_tail      : write wr_data into the tail this cycle
//   wr_data        : incoming {result, nzcv} entry
//   head           : current head entry
// ---------------------------------------------------------------------------
module buffer_resultado #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_head,
  input  logic         head_from_tail,
  input  logic         load_tail,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] head
);

  logic [W-1:0] tail;

  // NOTE: Both entries are reset, although this is a storage array. The head
  // drives result/nzcv, and those outputs must read zero while rst_n is low.
  // NOTE: Non-blocking assignments let the head read the old tail in the
  // same cycle that a new tail value is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (load_head) head <= head_from_tail ? tail : wr_data;
      if (load_tail) tail <= wr_data;
    end
  end

endmodule : buffer_resultado

// File: rtl/etapa_resultado_alu.sv
// ---------------------------------------------------------------------------
// etapa_resultado_alu
// Registers the result of an N-bit adder and derives its NZCV flags. The
// stage holds up to two entries in a buffer with a valid/ready handshake on
// each side. Entries leave in the order they arrived.
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset, empties the buffer at once
//   bus        : etapa_resultado_alu_if.slave
//                (in_valid/in_ready/c_in/flag_in/out_valid/out_ready/result/nzcv)
//   clr_sticky : clears sticky_v            (only with STICKY_FLAGS_EN)
//   sticky_v   : overflow seen since clear  (only with STICKY_FLAGS_EN)
// Optional feature macro: STICKY_FLAGS_EN.
// ---------------------------------------------------------------------------
module etapa_resultado_alu
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  etapa_resultado_alu_if.slave  bus
`ifdef STICKY_FLAGS_EN
  ,
  input  logic                  clr_sticky,
  output logic                  sticky_v
`endif
);

  localparam int W = N + 4;

  ocupacion_t   state;
  logic         push;
  logic         pop;
  logic         load_head;
  logic         head_from_tail;
  logic         load_tail;
  logic [W-1:0] wr_data;
  logic [W-1:0] head;

  // The handshake outputs come only from the registered state. out_ready
  // therefore has no combinational path to in_ready.
  assign bus.in_ready  = (state != LLENO);
  assign bus.out_valid = (state != VACIO);

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // The flags are derived only from the data being pushed.
  assign wr_data = {bus.c_in,
                    pack_nzcv(bus.c_in[N-1], (bus.c_in == '0),
                              bus.flag_in[FLAG_C], bus.flag_in[FLAG_V])};

  // NOTE: Every output gets a default before the case. Without the defaults,
  // a branch that does not assign an output would infer a latch.
  always_comb begin
    load_head      = 1'b0;
    head_from_tail = 1'b0;
    load_tail      = 1'b0;
    case (state)
      VACIO: load_head = push;
      UNO: begin
        // Push and pop in the same cycle: the new entry replaces the head.
        if (push && pop) load_head = 1'b1;
        else if (push)   load_tail = 1'b1;
      end
      LLENO: begin
        // The tail moves up to the head. No push can happen while full.
        if (pop) begin
          load_head      = 1'b1;
          head_from_tail = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= VACIO;
    end else begin
      case (state)
        VACIO: if (push) state <= UNO;
        UNO: begin
          if (push && !pop)      state <= LLENO;
          else if (pop && !push) state <= VACIO;
        end
        LLENO:   if (pop) state <= UNO;
        default: state <= VACIO;
      endcase
    end
  end

  buffer_resultado #(.W(W)) u_buffer (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_head      (load_head),
    .head_from_tail (head_from_tail),
    .load_tail      (load_tail),
    .wr_data        (wr_data),
    .head           (head)
  );

  assign bus.result = head[W-1:4];
  assign bus.nzcv   = head[3:0];

`ifdef STICKY_FLAGS_EN
  // When a set and a clear arrive in the same cycle, the set wins. An
  // overflow that arrives during a clear is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          sticky_v <= 1'b0;
    else if (push && bus.flag_in[FLAG_V]) sticky_v <= 1'b1;
    else if (clr_sticky)                 sticky_v <= 1'b0;
  end
`endif

endmodule : etapa_resultado_alu

// File: doc/etapa_resultado_alu.md
ETAPA_RESULTADO_ALU -- requirements
Module: etapa_resultado_alu

Interface
- REQ-001: Parameter N, default 8, operand/result width in bits.
- REQ-002: clk  input  1  single clock; all state updates on rising edge.
- REQ-003: rst_n  input  1  asynchronous, active-low reset.
- REQ-004: in_valid  input  1  adder result and flags on c_in/flag_in are valid.
- REQ-005: in_ready  output  1  block accepts a transfer this cycle.
- REQ-006: c_in  input  N  sum from the N-bit adder.
- REQ-007: flag_in  input  2  adder flags: bit0 = V (overflow), bit1 = C (carry-out).
- REQ-008: out_valid  output  1  result/nzcv hold a valid entry.
- REQ-009: out_ready  input  1  consumer accepts the head entry.
- REQ-010: result  output  N  registered sum at buffer head.
- REQ-011: nzcv  output  4  registered flags at head, order {N,Z,C,V}, bit3 = N.
- REQ-012: clr_sticky  input  1  clears sticky_v (present only with STICKY_FLAGS_EN).
- REQ-013: sticky_v  output  1  accumulated overflow (present only with STICKY_FLAGS_EN).

Function
- REQ-014: Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
- REQ-015: On push, N = c_in[N-1], Z = (c_in == 0), C = flag_in[1], V = flag_in[0], computed from the pushed data only.
- REQ-016: Storage is a 2-entry in-order buffer; entries leave in push order, never dropped or duplicated.
- REQ-017: Occupancy states: VACIO (0), UNO (1), LLENO (2).
- REQ-018: Transitions: VACIO+push -> UNO; UNO+push, no pop -> LLENO; UNO+pop, no push -> VACIO; UNO+push+pop -> UNO with new entry at head; LLENO+pop -> UNO; otherwise hold.
- REQ-019: in_ready = (state != LLENO), decoded from registered state only, no combinational path from out_ready.
- REQ-020: out_valid = (state != VACIO); result/nzcv change only on push into VACIO, on pop, or on simultaneous push/pop.
- REQ-021: Latency: data pushed in cycle k is visible on result/nzcv in cycle k+1 when the buffer was VACIO, or when it was UNO with a pop in cycle k.
- REQ-022: With in_valid and out_ready held high, throughput is one entry per cycle.
- REQ-023: When out_valid is high and out_ready is low, result and nzcv are held stable.
- REQ-024: In LLENO, a push request is ignored and in_valid data is not captured.

Reset
- REQ-025: While rst_n is low: state = VACIO, out_valid = 0, in_ready = 1, result = 0, nzcv = 4'b0000, sticky_v = 0.
- REQ-026: Reset asserted mid-operation discards all buffered entries immediately, without waiting for a clock edge.

Configuration
- REQ-027: Macro STICKY_FLAGS_EN; when defined, clr_sticky and sticky_v exist, and sticky_v sets on the cycle after a push with flag_in[0] = 1.
- REQ-028: With STICKY_FLAGS_EN, clr_sticky clears sticky_v on the next edge; a simultaneous set and clear leaves sticky_v = 1.
- REQ-029: Without STICKY_FLAGS_EN, neither port nor any sticky state exists; all other behaviour is identical.

Structure
- REQ-030: Shared package alu_pkg holds the NZCV bit-index constants (N=3, Z=2, C=1, V=0) and the occupancy state enum typedef.
- REQ-031: A single sub-module buffer_resultado implements the 2-entry {result, nzcv} storage; flag derivation and state control stay in etapa_resultado_alu.

Verification (N=8)
- REQ-032: Reset: assert rst_n=0 -> out_valid=0, in_ready=1, nzcv=0000, result=0x00.
- REQ-033: Push c_in=0x00, flag_in=2'b10, out_ready=1 -> next cycle out_valid=1, result=0x00, nzcv=0110; push c_in=0x80, flag_in=2'b01 -> result=0x80, nzcv=1001.
- REQ-034: Backpressure: out_ready=0, push 0x11, 0x22, then offer 0x33 -> in_ready=0 after the second push, and 0x33 is not taken; raise out_ready -> outputs 0x11 then 0x22, and 0x33 is accepted once in_ready=1.
- REQ-035: Streaming: in_valid=1 and out_ready=1 for 10 cycles with c_in=1..10 -> result=1..10 on consecutive cycles, one cycle behind.
- REQ-036: Reset in LLENO (entries 0x11, 0x22) between edges -> out_valid=0 and in_ready=1 immediately, and no stale entry appears after release.
- REQ-037: STICKY_FLAGS_EN: push flag_in=2'b01 -> sticky_v=1 and stays 1 through later V=0 pushes; clr_sticky during a V=1 push -> sticky_v stays 1; clr_sticky alone -> sticky_v=0.
